// File: rtl/board_input_conditioner.sv
// Board input conditioner for the FlexPRET core. It synchronises and debounces the DE1-SoC switches and keys,
// turns accepted key edges into pulses and sticky interrupts, and synchronises the UART RX pin.
module board_input_conditioner #(
    parameter int                   NUM_SW          = 10,
    parameter int                   NUM_KEY         = 4,
    parameter int                   SYNC_STAGES     = 2,
    parameter int                   DEBOUNCE_CYCLES = 500000,
    parameter logic [2*NUM_KEY-1:0] KEY_EDGE_MODE   = {NUM_KEY{2'b00}}
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_SW-1:0]  sw_raw,
    input  logic [NUM_KEY-1:0] key_raw_n,
    input  logic               uart_rx_raw,
    input  logic [NUM_KEY-1:0] irq_ack,
    output logic [NUM_SW-1:0]  sw_clean,
    output logic [NUM_KEY-1:0] key_clean,
    output logic [NUM_KEY-1:0] key_event,
    output logic [NUM_KEY-1:0] key_irq,
    output logic               uart_rx_sync
);
    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int               NUM_CH   = NUM_SW + NUM_KEY;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        EDGE_PRESS   = 2'b00,
        EDGE_RELEASE = 2'b01,
        EDGE_BOTH    = 2'b10,
        EDGE_NONE    = 2'b11
    } edge_mode_e;

    // Stage 0 samples the pin, and stage SYNC_STAGES-1 is the synchronised value.
    logic [SYNC_STAGES-1:0][NUM_SW-1:0]  r_sw_sync;
    logic [SYNC_STAGES-1:0][NUM_KEY-1:0] r_key_sync;
    logic [SYNC_STAGES-1:0]              r_uart_sync;

    logic [NUM_CH-1:0]  r_stable;
    logic [CNT_W-1:0]   r_cnt [NUM_CH];
    logic [NUM_KEY-1:0] r_key_event;
    logic [NUM_KEY-1:0] r_key_irq;

    logic [NUM_CH-1:0]  w_synced;
    logic [NUM_CH-1:0]  w_accept;
    logic [NUM_KEY-1:0] w_key_hit;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sw_sync   <= '0;
            r_key_sync  <= '1;
            r_uart_sync <= '1;
        end else begin
            r_sw_sync   <= {r_sw_sync[SYNC_STAGES-2:0], sw_raw};
            r_key_sync  <= {r_key_sync[SYNC_STAGES-2:0], key_raw_n};
            r_uart_sync <= {r_uart_sync[SYNC_STAGES-2:0], uart_rx_raw};
        end
    end

    // Keys are debounced as active-high "pressed", so they share the switch datapath.
    assign w_synced = {~r_key_sync[SYNC_STAGES-1], r_sw_sync[SYNC_STAGES-1]};

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can leave a latch behind.
        w_accept  = '0;
        w_key_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_accept[i] = (w_synced[i] != r_stable[i]) && (r_cnt[i] == CNT_LAST);
        end
        for (int k = 0; k < NUM_KEY; k++) begin
            if (w_accept[NUM_SW+k]) begin
                case (edge_mode_e'(KEY_EDGE_MODE[2*k +: 2]))
                    EDGE_PRESS:   w_key_hit[k] = w_synced[NUM_SW+k];
                    EDGE_RELEASE: w_key_hit[k] = ~w_synced[NUM_SW+k];
                    EDGE_BOTH:    w_key_hit[k] = 1'b1;
                    default:      w_key_hit[k] = 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stable <= '0;
            // NOTE: the counter array is cleared on reset, so a change in progress is dropped and not resumed.
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_synced[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_accept[i]) begin
                    r_stable[i] <= w_synced[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Masking with the previous pulse keeps events one cycle wide even when DEBOUNCE_CYCLES is 1.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_key_event <= '0;
            r_key_irq   <= '0;
        end else begin
            r_key_event <= w_key_hit & ~r_key_event;
            r_key_irq   <= r_key_event | (r_key_irq & ~irq_ack);
        end
    end

    assign sw_clean     = r_stable[NUM_SW-1:0];
    assign key_clean    = r_stable[NUM_CH-1:NUM_SW];
    assign key_event    = r_key_event;
    assign key_irq      = r_key_irq;
    assign uart_rx_sync = r_uart_sync[SYNC_STAGES-1];

endmodule

// File: tb/tb_board_input_conditioner.sv
// Scoreboard bench for board_input_conditioner: each stimulus step queues the outputs it should cause at given
// clock edges, and a negedge monitor compares the outputs when those edges arrive.
module tb_board_input_conditioner;
    localparam int NUM_SW          = 10;
    localparam int NUM_KEY         = 4;
    localparam int SYNC_STAGES     = 2;
    localparam int DEBOUNCE_CYCLES = 4;
    localparam int LAT             = SYNC_STAGES + DEBOUNCE_CYCLES - 1;
    localparam logic [31:0] SW_ALL  = 32'h3FF;
    localparam logic [31:0] KEY_ALL = 32'hF;

    logic               clock = 1'b0;
    logic               reset_n;
    logic [NUM_SW-1:0]  sw_raw;
    logic [NUM_KEY-1:0] key_raw_n;
    logic               uart_rx_raw;
    logic [NUM_KEY-1:0] irq_ack;
    logic [NUM_SW-1:0]  sw_clean;
    logic [NUM_KEY-1:0] key_clean;
    logic [NUM_KEY-1:0] key_event;
    logic [NUM_KEY-1:0] key_irq;
    logic               uart_rx_sync;

    board_input_conditioner #(
        .NUM_SW          (NUM_SW),
        .NUM_KEY         (NUM_KEY),
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .KEY_EDGE_MODE   (8'b11_10_01_00)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .sw_raw       (sw_raw),
        .key_raw_n    (key_raw_n),
        .uart_rx_raw  (uart_rx_raw),
        .irq_ack      (irq_ack),
        .sw_clean     (sw_clean),
        .key_clean    (key_clean),
        .key_event    (key_event),
        .key_irq      (key_irq),
        .uart_rx_sync (uart_rx_sync)
    );

    always #10 clock = ~clock;

    typedef enum {SIG_SW, SIG_KCLEAN, SIG_KEVENT, SIG_KIRQ, SIG_UART} sig_e;

    typedef struct {
        int unsigned at_edge;
        sig_e        sig;
        logic [31:0] mask;
        logic [31:0] value;
        string       tag;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned n_edge   = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    always @(posedge clock) n_edge <= n_edge + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, obs, exp, n_edge);
        end
    endtask

    // The queue stays sorted by edge, so the monitor only needs to look at its head.
    task automatic expect_at(input int unsigned at_edge, input sig_e sig, input logic [31:0] mask,
                             input logic [31:0] value, input string tag);
        exp_t item;
        int   idx;
        item.at_edge = at_edge;
        item.sig     = sig;
        item.mask    = mask;
        item.value   = value;
        item.tag     = tag;
        idx = sb_q.size();
        while (idx > 0 && sb_q[idx-1].at_edge > at_edge) idx--;
        sb_q.insert(idx, item);
    endtask

    function automatic logic [31:0] observe(input sig_e sig);
        case (sig)
            SIG_SW:     return 32'(sw_clean);
            SIG_KCLEAN: return 32'(key_clean);
            SIG_KEVENT: return 32'(key_event);
            SIG_KIRQ:   return 32'(key_irq);
            default:    return 32'(uart_rx_sync);
        endcase
    endfunction

    always @(negedge clock) begin
        exp_t item;
        while (sb_q.size() > 0 && sb_q[0].at_edge <= n_edge) begin
            item = sb_q.pop_front();
            check(item.tag, observe(item.sig) & item.mask, item.value & item.mask);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        #100us;
        $display("FAIL watchdog: simulation did not complete, expected completion well within 100us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned e;
        reset_n     = 1'b0;
        sw_raw      = '1;
        key_raw_n   = '0;
        uart_rx_raw = 1'b1;
        irq_ack     = '0;
        tick(3);
        check("rst_sw_clean",  32'(sw_clean),     32'h0);
        check("rst_key_clean", 32'(key_clean),    32'h0);
        check("rst_key_event", 32'(key_event),    32'h0);
        check("rst_key_irq",   32'(key_irq),      32'h0);
        check("rst_uart",      32'(uart_rx_sync), 32'h1);

        // The first edge after reset release samples the switches, which are already high.
        reset_n   = 1'b1;
        key_raw_n = '1;
        e = n_edge;
        expect_at(e + LAT,     SIG_SW,     SW_ALL,  32'h0,  "rel_sw_still_low");
        expect_at(e + LAT + 1, SIG_SW,     SW_ALL,  SW_ALL, "rel_sw_high");
        expect_at(e + LAT + 1, SIG_KCLEAN, KEY_ALL, 32'h0,  "rel_key_released");
        tick(LAT + 3);

        // Clean press on key0, which is in press mode.
        key_raw_n[0] = 1'b0;
        e = n_edge;
        expect_at(e + LAT,     SIG_KCLEAN, 32'h1,   32'h0, "k0_press_early");
        expect_at(e + LAT + 1, SIG_KCLEAN, 32'h1,   32'h1, "k0_press_clean");
        expect_at(e + LAT + 1, SIG_KEVENT, KEY_ALL, 32'h1, "k0_press_event");
        expect_at(e + LAT + 1, SIG_KIRQ,   KEY_ALL, 32'h0, "k0_irq_not_yet");
        expect_at(e + LAT + 2, SIG_KEVENT, KEY_ALL, 32'h0, "k0_event_one_cycle");
        expect_at(e + LAT + 2, SIG_KIRQ,   KEY_ALL, 32'h1, "k0_irq_set");
        expect_at(e + LAT + 5, SIG_KIRQ,   KEY_ALL, 32'h1, "k0_irq_sticky");
        tick(LAT + 5);
        irq_ack[0] = 1'b1;
        e = n_edge;
        expect_at(e + 1, SIG_KIRQ, KEY_ALL, 32'h0, "k0_irq_ack");
        tick(1);
        irq_ack[0] = 1'b0;
        key_raw_n[0] = 1'b1;
        e = n_edge;
        expect_at(e + LAT,     SIG_KCLEAN, 32'h1,   32'h1, "k0_release_early");
        expect_at(e + LAT + 1, SIG_KCLEAN, 32'h1,   32'h0, "k0_release_clean");
        expect_at(e + LAT + 1, SIG_KEVENT, KEY_ALL, 32'h0, "k0_release_no_event");
        expect_at(e + LAT + 2, SIG_KIRQ,   KEY_ALL, 32'h0, "k0_release_no_irq");
        tick(LAT + 3);

        // Bounce on sw3: bring it low first, then toggle every two cycles, then settle high.
        sw_raw[3] = 1'b0;
        e = n_edge;
        expect_at(e + LAT + 1, SIG_SW, SW_ALL, 32'h3F7, "sw3_low");
        tick(LAT + 3);
        for (int c = 0; c < 20; c++) begin
            sw_raw[3] = ((c / 2) % 2 == 0);
            expect_at(n_edge + 1, SIG_SW, SW_ALL, 32'h3F7, "sw3_bounce_ignored");
            tick(1);
        end
        sw_raw[3] = 1'b1;
        e = n_edge;
        for (int d = 1; d <= LAT; d++) begin
            expect_at(e + d, SIG_SW, 32'h8, 32'h0, "sw3_settling");
        end
        expect_at(e + LAT + 1, SIG_SW, SW_ALL, SW_ALL, "sw3_settled");
        tick(LAT + 3);

        // Edge modes: key1 fires on release, key2 on both edges, key3 never.
        key_raw_n[3:1] = 3'b000;
        e = n_edge;
        expect_at(e + LAT + 1, SIG_KCLEAN, KEY_ALL, 32'hE, "k123_press_clean");
        expect_at(e + LAT + 1, SIG_KEVENT, KEY_ALL, 32'h4, "k123_press_event");
        expect_at(e + LAT + 2, SIG_KEVENT, KEY_ALL, 32'h0, "k123_press_pulse");
        expect_at(e + LAT + 2, SIG_KIRQ,   KEY_ALL, 32'h4, "k123_press_irq");
        tick(LAT + 3);
        key_raw_n[3:1] = 3'b111;
        e = n_edge;
        expect_at(e + LAT + 1, SIG_KCLEAN, KEY_ALL, 32'h0, "k123_release_clean");
        expect_at(e + LAT + 1, SIG_KEVENT, KEY_ALL, 32'h6, "k123_release_event");
        expect_at(e + LAT + 2, SIG_KEVENT, KEY_ALL, 32'h0, "k123_release_pulse");
        expect_at(e + LAT + 2, SIG_KIRQ,   KEY_ALL, 32'h6, "k123_release_irq");
        tick(LAT + 3);
        irq_ack = '1;
        e = n_edge;
        expect_at(e + 1, SIG_KIRQ, KEY_ALL, 32'h0, "ack_all");
        tick(1);
        irq_ack = '0;

        // Set/ack collision: the ack is held during the cycle in which key_event[0] is high.
        key_raw_n[0] = 1'b0;
        e = n_edge;
        expect_at(e + LAT + 1, SIG_KEVENT, KEY_ALL, 32'h1, "collide_event");
        expect_at(e + LAT + 2, SIG_KIRQ,   32'h1,   32'h1, "collide_set_wins");
        expect_at(e + LAT + 3, SIG_KIRQ,   32'h1,   32'h1, "collide_sticky");
        tick(LAT + 1);
        irq_ack[0] = 1'b1;
        tick(1);
        irq_ack[0] = 1'b0;
        tick(2);
        irq_ack[0] = 1'b1;
        e = n_edge;
        expect_at(e + 1, SIG_KIRQ, 32'h1, 32'h0, "level_ack_clear");
        expect_at(e + 3, SIG_KIRQ, 32'h1, 32'h0, "level_ack_held");
        tick(3);
        irq_ack[0]   = 1'b0;
        key_raw_n[0] = 1'b1;
        tick(LAT + 3);

        // Reset mid-debounce: the pending key1 press must be discarded.
        key_raw_n[1] = 1'b0;
        tick(3);
        reset_n      = 1'b0;
        key_raw_n[1] = 1'b1;
        tick(1);
        check("mid_rst_sw_clean",  32'(sw_clean),     32'h0);
        check("mid_rst_key_clean", 32'(key_clean),    32'h0);
        check("mid_rst_key_irq",   32'(key_irq),      32'h0);
        check("mid_rst_uart",      32'(uart_rx_sync), 32'h1);
        tick(1);
        reset_n = 1'b1;
        e = n_edge;
        for (int d = 1; d <= LAT + 3; d++) begin
            expect_at(e + d, SIG_KCLEAN, KEY_ALL, 32'h0, "mid_rst_no_key_clean");
            expect_at(e + d, SIG_KEVENT, 32'h2,   32'h0, "mid_rst_no_event");
            expect_at(e + d, SIG_KIRQ,   32'h2,   32'h0, "mid_rst_no_irq");
        end
        expect_at(e + LAT + 1, SIG_SW, SW_ALL, SW_ALL, "mid_rst_sw_recovered");
        tick(LAT + 4);

        // The UART path is synchronised only, with no debounce.
        uart_rx_raw = 1'b0;
        e = n_edge;
        expect_at(e + 1, SIG_UART, 32'h1, 32'h1, "uart_still_high");
        expect_at(e + 2, SIG_UART, 32'h1, 32'h0, "uart_low");
        tick(3);
        uart_rx_raw = 1'b1;
        e = n_edge;
        expect_at(e + 1, SIG_UART, 32'h1, 32'h0, "uart_still_low");
        expect_at(e + 2, SIG_UART, 32'h1, 32'h1, "uart_high");

        for (int w = 0; w < 50 && sb_q.size() > 0; w++) tick(1);
        check("scoreboard_drained", 32'(sb_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
